// File: rtl/switch_out_arbiter_if.sv
// switch_out_arbiter_if: request/beat handshake between the input ports and one output-port arbiter
interface switch_out_arbiter_if #(parameter int NUM_PORTS = 4);
  localparam int SW = $clog2(NUM_PORTS);
  logic [NUM_PORTS-1:0] req_i, vld_i, eop_i, gnt_o;
  logic out_rdy_i, out_vld_o;
  logic [SW-1:0] sel_o;
  modport master (output req_i, vld_i, eop_i, out_rdy_i, input gnt_o, sel_o, out_vld_o);
  modport slave (input req_i, vld_i, eop_i, out_rdy_i, output gnt_o, sel_o, out_vld_o);
endinterface

// File: rtl/switch_out_arbiter.sv
// switch_out_arbiter: round-robin output arbiter with packet locking; stall timeout via SWITCH_ARB_TIMEOUT_EN
module switch_out_arbiter #(
  parameter int NUM_PORTS = 4,
  parameter int CNT_W = 16,
  parameter int TIMEOUT = 64
) (
  input logic clk,
  input logic rst,
  switch_out_arbiter_if.slave bus,
  output logic busy_o,
  output logic [CNT_W-1:0] pkt_cnt_o,
  output logic timeout_o
);
  localparam int SW = $clog2(NUM_PORTS);
  typedef enum logic {IDLE, LOCK} state_t;
  state_t state_q, state_d;
  logic [NUM_PORTS-1:0] gnt_q, gnt_d;
  logic [SW-1:0] sel_q, sel_d, ptr_q, ptr_d, win, idx;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic xfer, done, timeout_d;
  // scan downwards so the port closest to ptr is the last (winning) assignment
  always_comb begin
    win = ptr_q;
    idx = '0;
    for (int k = NUM_PORTS - 1; k >= 0; k--) begin
      idx = SW'((int'(ptr_q) + k) % NUM_PORTS);
      if (bus.req_i[idx]) win = idx;
    end
  end
  assign bus.out_vld_o = (state_q == LOCK) & bus.vld_i[sel_q];
  assign xfer = bus.out_vld_o & bus.out_rdy_i;
  assign done = xfer & bus.eop_i[sel_q];
  always_comb begin
    state_d = state_q;
    gnt_d = gnt_q;
    sel_d = sel_q;
    ptr_d = ptr_q;
    cnt_d = (done && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
    if (state_q == IDLE && bus.req_i != '0) begin
      state_d = LOCK;
      gnt_d = NUM_PORTS'(1) << win;
      sel_d = win;
      ptr_d = (int'(win) == NUM_PORTS - 1) ? '0 : win + 1'b1;
    end else if (done || timeout_d) begin
      state_d = IDLE;
      gnt_d = '0;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q <= '0;
      sel_q <= '0;
      ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      gnt_q <= gnt_d;
      sel_q <= sel_d;
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end
`ifdef SWITCH_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] stall_q, stall_d;
  logic timeout_q;
  // a transfer on the expiring cycle clears the count instead of releasing
  assign timeout_d = (state_q == LOCK) && !xfer && (int'(stall_q) == TIMEOUT - 1);
  assign stall_d = (state_q == LOCK && !xfer && !timeout_d) ? stall_q + 1'b1 : '0;
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
      timeout_q <= 1'b0;
    end else begin
      stall_q <= stall_d;
      timeout_q <= timeout_d;
    end
  end
  assign timeout_o = timeout_q;
`else
  assign timeout_d = 1'b0;
  assign timeout_o = 1'b0;
`endif
  assign bus.gnt_o = gnt_q;
  assign bus.sel_o = sel_q;
  assign busy_o = (state_q == LOCK);
  assign pkt_cnt_o = cnt_q;
endmodule

// File: tb/tb_switch_out_arbiter.sv
// tb_switch_out_arbiter: scenario tasks plus randomized traffic against a packet-level reference model
module tb_switch_out_arbiter;
  localparam int N = 4;
  localparam int SW = 2;
  localparam int CNT_W = 4;
  localparam int TIMEOUT = 4;
`ifdef SWITCH_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif
  localparam int STALL = TO_EN ? TIMEOUT - 1 : 10;
  typedef logic [N+SW+CNT_W+2:0] vec_t;
  logic clk = 1'b0;
  logic rst;
  logic busy, to;
  logic [CNT_W-1:0] cnt;
  int n_tests = 0;
  int n_fail = 0;
  bit m_lock, m_to;
  int m_own, m_ptr, m_cnt, m_stall, m_beat;
  switch_out_arbiter_if #(.NUM_PORTS(N)) bus ();
  switch_out_arbiter #(.NUM_PORTS(N), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .bus(bus), .busy_o(busy), .pkt_cnt_o(cnt), .timeout_o(to)
  );
  always #5 clk = ~clk;
  task automatic set_in(input logic r_rst, input logic [N-1:0] r, v, e, input logic o);
    rst = r_rst;
    bus.req_i = r;
    bus.vld_i = v;
    bus.eop_i = e;
    bus.out_rdy_i = o;
    #1;
  endtask
  // reference: packet owner, fairness pointer and counters advanced once per clock edge
  task automatic tick();
    bit found;
    @(posedge clk);
    if (rst) begin
      {m_lock, m_to} = '0;
      {m_own, m_ptr, m_cnt, m_stall, m_beat} = '0;
    end else begin
      m_to = 1'b0;
      if (!m_lock) begin
        found = 1'b0;
        for (int k = 0; k < N; k++)
          if (!found && bus.req_i[(m_ptr + k) % N]) begin
            found = 1'b1;
            m_own = (m_ptr + k) % N;
          end
        if (found) begin
          m_lock = 1'b1;
          m_ptr = (m_own + 1) % N;
          m_stall = 0;
          m_beat = 0;
        end
      end else if (bus.vld_i[m_own] && bus.out_rdy_i) begin
        m_stall = 0;
        m_beat++;
        if (bus.eop_i[m_own]) begin
          m_lock = 1'b0;
          if (m_cnt < 2 ** CNT_W - 1) m_cnt++;
        end
      end else if (TO_EN) begin
        m_stall++;
        if (m_stall == TIMEOUT) begin
          m_lock = 1'b0;
          m_to = 1'b1;
          m_stall = 0;
        end
      end
    end
    #1;
  endtask
  task automatic do_reset(input int n);
    repeat (n) begin
      set_in(1'b1, '0, '0, '0, 1'b0);
      tick();
    end
  endtask
  function automatic vec_t obs();
    return {bus.gnt_o, bus.sel_o, bus.out_vld_o, busy, cnt, to};
  endfunction
  function automatic vec_t mdl();
    return {m_lock ? N'(1) << m_own : N'(0), SW'(m_own), m_lock & bus.vld_i[m_own], m_lock, CNT_W'(m_cnt), m_to};
  endfunction
  task automatic test_reset();
    do_reset(2);
    for (int i = 0; i < 4; i++) begin
      set_in(1'b0, '0, '0, '0, 1'b1);
      n_tests++;
      if ({bus.gnt_o, bus.sel_o, busy, cnt, to} !== '0) begin
        n_fail++;
        $display("FAIL reset_idle cyc %0d: got gnt=%b sel=%0d busy=%b cnt=%0d to=%b, want all zero", i, bus.gnt_o, bus.sel_o, busy, cnt, to);
      end
      tick();
    end
  endtask
  task automatic test_round_robin();
    string seq = "";
    int busy_cyc = 0;
    logic prev = 1'b0;
    do_reset(1);
    for (int i = 0; i < 20; i++) begin
      set_in(1'b0, 4'hF, 4'hF, (m_lock && m_beat == 2) ? 4'hF : 4'h0, 1'b1);
      n_tests++;
      if (obs() !== mdl()) begin
        n_fail++;
        $display("FAIL rr_model cyc %0d: dut %h model %h", i, obs(), mdl());
      end
      if (busy && !prev) seq = {seq, $sformatf("%0d", bus.sel_o)};
      prev = busy;
      busy_cyc += int'(busy);
      tick();
    end
    set_in(1'b0, 4'hF, 4'hF, 4'h0, 1'b1);
    n_tests++;
    if (seq != "01230" || busy_cyc != 15 || cnt !== 4'd5) begin
      n_fail++;
      $display("FAIL rr_order: order %s busy %0d cnt %0d, want order 01230 busy 15 cnt 5", seq, busy_cyc, cnt);
    end
    tick();
  endtask
  task automatic test_stall();
    do_reset(1);
    set_in(1'b0, 4'b0100, '0, '0, 1'b1);
    tick();
    set_in(1'b0, 4'b1011, 4'hF, '0, 1'b1);
    tick();
    for (int i = 0; i < STALL; i++) begin
      set_in(1'b0, 4'b1011, 4'hF, 4'hF, 1'b0);
      n_tests++;
      if (bus.gnt_o !== 4'b0100 || busy !== 1'b1 || obs() !== mdl()) begin
        n_fail++;
        $display("FAIL stall_hold cyc %0d: dut %h model %h gnt %b want 0100", i, obs(), mdl(), bus.gnt_o);
      end
      tick();
    end
    set_in(1'b0, 4'b1011, 4'hF, 4'b1011, 1'b1);
    tick();
    set_in(1'b0, 4'b1011, 4'hF, 4'b0100, 1'b1);
    n_tests++;
    if (bus.gnt_o !== 4'b0100 || cnt !== 4'd0) begin
      n_fail++;
      $display("FAIL stall_foreign_eop: gnt %b cnt %0d, want 0100 cnt 0", bus.gnt_o, cnt);
    end
    tick();
    set_in(1'b0, 4'b1011, '0, '0, 1'b1);
    n_tests++;
    if (bus.gnt_o !== 4'b0000 || busy !== 1'b0 || cnt !== 4'd1) begin
      n_fail++;
      $display("FAIL stall_release: gnt %b busy %b cnt %0d, want 0000 0 1", bus.gnt_o, busy, cnt);
    end
    tick();
  endtask
  task automatic test_single_beat();
    do_reset(1);
    set_in(1'b0, 4'b0010, '0, '0, 1'b1);
    tick();
    set_in(1'b0, 4'b0011, 4'b0010, 4'b0010, 1'b1);
    n_tests++;
    if (bus.gnt_o !== 4'b0010 || bus.out_vld_o !== 1'b1) begin
      n_fail++;
      $display("FAIL single_lock: gnt %b out_vld %b, want 0010 1", bus.gnt_o, bus.out_vld_o);
    end
    tick();
    set_in(1'b0, 4'b0011, '0, '0, 1'b1);
    n_tests++;
    if (bus.gnt_o !== 4'b0000 || busy !== 1'b0 || cnt !== 4'd1 || obs() !== mdl()) begin
      n_fail++;
      $display("FAIL single_bubble: dut %h model %h", obs(), mdl());
    end
    tick();
    set_in(1'b0, 4'b0011, '0, '0, 1'b1);
    n_tests++;
    if (bus.gnt_o !== 4'b0001 || bus.sel_o !== 2'd0 || obs() !== mdl()) begin
      n_fail++;
      $display("FAIL single_next_grant: gnt %b sel %0d, want 0001 0", bus.gnt_o, bus.sel_o);
    end
    tick();
  endtask
  task automatic test_reset_mid();
    do_reset(1);
    set_in(1'b0, 4'b0010, 4'hF, 4'hF, 1'b1);
    tick();
    tick();
    set_in(1'b0, 4'b1000, 4'hF, '0, 1'b1);
    tick();
    set_in(1'b0, 4'b1000, 4'hF, '0, 1'b1);
    n_tests++;
    if (bus.gnt_o !== 4'b1000 || cnt !== 4'd1) begin
      n_fail++;
      $display("FAIL mid_pre: gnt %b cnt %0d, want 1000 1", bus.gnt_o, cnt);
    end
    tick();
    set_in(1'b1, 4'b1001, 4'hF, '0, 1'b1);
    tick();
    set_in(1'b0, 4'b1001, 4'hF, '0, 1'b1);
    n_tests++;
    if (bus.gnt_o !== 4'b0000 || busy !== 1'b0 || cnt !== 4'd0 || obs() !== mdl()) begin
      n_fail++;
      $display("FAIL mid_after_rst: gnt %b busy %b cnt %0d, want 0000 0 0", bus.gnt_o, busy, cnt);
    end
    tick();
    set_in(1'b0, 4'b1001, 4'hF, '0, 1'b1);
    n_tests++;
    if (bus.gnt_o !== 4'b0001 || bus.sel_o !== 2'd0) begin
      n_fail++;
      $display("FAIL mid_first_grant: gnt %b sel %0d, want 0001 0", bus.gnt_o, bus.sel_o);
    end
    tick();
  endtask
  task automatic test_timeout();
    do_reset(1);
    set_in(1'b0, 4'b0001, '0, '0, 1'b1);
    tick();
`ifdef SWITCH_ARB_TIMEOUT_EN
    for (int i = 0; i < 8; i++) begin
      set_in(1'b0, '0, '0, '0, 1'b1);
      n_tests++;
      if (busy !== (i < TIMEOUT) || to !== (i == TIMEOUT) || cnt !== 4'd0 || obs() !== mdl()) begin
        n_fail++;
        $display("FAIL timeout cyc %0d: busy %b to %b cnt %0d, want busy %b to %b cnt 0", i, busy, to, cnt, i < TIMEOUT, i == TIMEOUT);
      end
      tick();
    end
`else
    for (int i = 0; i < 110; i++) begin
      set_in(1'b0, '0, '0, '0, 1'b1);
      n_tests++;
      if (busy !== 1'b1 || to !== 1'b0 || bus.gnt_o !== 4'b0001) begin
        n_fail++;
        $display("FAIL no_timeout cyc %0d: busy %b to %b gnt %b, want 1 0 0001", i, busy, to, bus.gnt_o);
      end
      tick();
    end
`endif
  endtask
  task automatic test_saturation();
    do_reset(1);
    for (int i = 0; i < 40; i++) begin
      set_in(1'b0, 4'hF, 4'hF, 4'hF, 1'b1);
      n_tests++;
      if (obs() !== mdl()) begin
        n_fail++;
        $display("FAIL sat_model cyc %0d: dut %h model %h", i, obs(), mdl());
      end
      tick();
    end
    set_in(1'b0, '0, '0, '0, 1'b1);
    n_tests++;
    if (cnt !== CNT_W'(2 ** CNT_W - 1)) begin
      n_fail++;
      $display("FAIL sat_cnt: cnt %0d, want %0d", cnt, 2 ** CNT_W - 1);
    end
    tick();
  endtask
  task automatic test_random();
    do_reset(1);
    for (int i = 0; i < 800; i++) begin
      set_in($urandom_range(0, 63) == 0, N'($urandom), N'($urandom | $urandom), N'($urandom & $urandom),
             $urandom_range(0, 3) != 0);
      n_tests++;
      if (obs() !== mdl()) begin
        n_fail++;
        $display("FAIL random cyc %0d: dut %h model %h", i, obs(), mdl());
      end
      tick();
    end
  endtask
  initial begin
    test_reset();
    test_round_robin();
    test_stall();
    test_single_beat();
    test_reset_mid();
    test_timeout();
    test_saturation();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
